ghash_sched: RTL and testbench
==============================

# ghash_sched

Sequencing controller for the GCM authentication path. Accepts 128-bit AAD and ciphertext blocks over a valid/ready stream and drives a fixed-latency pipelined GF(2^128) multiplier with the chained GHASH recurrence Y_i = (Y_{i-1} xor X_i) * H. It appends the GCM length block automatically and emits the final tag = GHASH xor E(K,Y0). It sits between the block-cipher/CTR stage and the shared multiplier, and owns the multiplier's operands for the whole message.

## Interface
- MUL_LAT, 3: multiplier latency in clock edges from operand load to result capture; legal range 1..15.
- clk  in  1  system clock; all logic on posedge.
- i_reset  in  1  synchronous, active-high reset.
- h_key  in  [0:127]  hash subkey H; sampled on acceptance of the first block of each message.
- ek0  in  [0:127]  E(K,Y0); sampled on acceptance of the block with in_last=1.
- in_valid  in  1  block present.
- in_ready  out  1  controller can accept a block this cycle.
- in_data  in  [0:127]  block, GCM bit order (bit 0 = x^0 coefficient).
- in_aad  in  1  1 = AAD block, 0 = ciphertext block.
- in_last  in  1  final block of the message.
- mul_x  out  [0:127]  multiplier operand 1 (registered).
- mul_h  out  [0:127]  multiplier operand 2 (registered, = latched H).
- mul_res  in  [0:127]  multiplier product.
- tag  out  [0:127]  authentication tag, held until the next tag.
- tag_valid  out  1  one-cycle pulse when tag updates.
- busy  out  1  high while a message is in progress (first block accepted, tag not yet emitted).

## Operation
- States: IDLE, WAIT_BLK, WAIT_LEN.
- Registers: Y[0:127], h_reg, ek0_reg, aad_cnt[31:0], ct_cnt[31:0], lat_cnt[3:0], first flag, last flag.
- in_ready = 1 only in IDLE with i_reset low. Handshake = in_valid & in_ready.
- On handshake:
  - If this is the first block of a message, load h_reg <= h_key and use Y = 0.
  - mul_x <= Y xor in_data; mul_h <= h_reg (or h_key on the first block).
  - Increment aad_cnt if in_aad, else ct_cnt.
  - If in_last, ek0_reg <= ek0.
  - lat_cnt <= MUL_LAT; state <= WAIT_BLK.
- WAIT_BLK: lat_cnt decrements each edge. On the edge where it reaches 0, Y <= mul_res. Then:
  - If last: mul_x <= mul_res xor L, where L = {aad_cnt*128 as 64-bit, ct_cnt*128 as 64-bit} (bit 0..63 = len(A), 64..127 = len(C), big-endian bit lengths, as in GCM); reload lat_cnt; state <= WAIT_LEN.
  - Otherwise: state <= IDLE.
- WAIT_LEN: on the edge where lat_cnt reaches 0:
  - tag <= mul_res xor ek0_reg; tag_valid <= 1.
  - Clear Y, counters and first/last; state <= IDLE.
- Block counters wrap mod 2^32. Bit length is the 32-bit count shifted left by 7, zero-extended to 64 bits.
- AAD/ciphertext ordering is not checked; blocks are hashed in arrival order and counted by in_aad.
- Every message has at least one block. There is no empty-message path.

## Timing
- Reset values: in_ready=0 while i_reset high; tag=0, tag_valid=0, busy=0, mul_x=0, mul_h=0; state IDLE; Y and counters 0.
- i_reset has priority over any handshake or pending result. Reset mid-message discards it with no tag_valid. in_ready=1 on the first cycle after reset deasserts.
- Block accepted at edge e: mul_x is valid after e; mul_res is captured at edge e+MUL_LAT; in_ready is high again in the cycle after e+MUL_LAT.
- Sustained throughput: one block per MUL_LAT+1 cycles.
- Last block accepted at edge e: length block loaded at e+MUL_LAT; tag and tag_valid at edge e+2*MUL_LAT.
- Next message can be accepted at e+2*MUL_LAT+1, i.e. in the same cycle tag_valid is high. That is legal, and tag holds until the next tag.
- mul_h is stable from first-block acceptance to tag emission. h_key changes mid-message are ignored.
- in_data, in_aad and in_last are only sampled on handshake.

## Test plan
- Reset: hold i_reset 3 cycles with in_valid=1 -> no handshake, tag=0, tag_valid=0, busy=0; in_ready=1 on the first cycle after release.
- H=0, one ciphertext block 0x0123..EF, ek0=0xAAAA...A -> tag=0xAAAA...A exactly 2*MUL_LAT edges after acceptance; tag_valid high for 1 cycle.
- H=identity (bit 0 set, 0x80..0), one ciphertext block X, ek0=0 -> tag = X xor 0x0000000000000000_0000000000000080.
- H=identity, 2 AAD + 3 ciphertext blocks with in_valid held high -> accepts spaced MUL_LAT+1 cycles apart; L = {64'd256, 64'd384}; tag = xor of all blocks xor L.
- Random H and blocks against a reference GHASH model, MUL_LAT in {1,3,7}; change h_key mid-message -> tag matches the model using the H sampled at the first block.
- Assert i_reset during WAIT_LEN -> no tag_valid, prior tag cleared to 0; a following 1-block message produces the correct tag.

Source files
------------

// File: rtl/ghash_sched.sv
// ghash_sched
//   Sequencing controller for the GCM authentication path. It accepts 128-bit
//   AAD / ciphertext blocks over a valid/ready stream and drives an external
//   fixed-latency GF(2^128) multiplier with the GHASH recurrence
//   Y_i = (Y_{i-1} xor X_i) * H. After the last block it appends the GCM
//   length block {len(A), len(C)} and emits tag = GHASH xor E(K,Y0).
//
//   All 128-bit buses use GCM bit order: index 0 is the x^0 coefficient and
//   is the leftmost (most significant) bit of a hex literal.
//
// Ports
//   clk        system clock, all logic on posedge
//   i_reset    synchronous active-high reset, priority over everything
//   h_key      hash subkey H, sampled when the first block of a message is accepted
//   ek0        E(K,Y0), sampled when the block with in_last=1 is accepted
//   in_valid   block present
//   in_ready   controller can accept a block this cycle
//   in_data    block data
//   in_aad     1 = AAD block, 0 = ciphertext block
//   in_last    final block of the message
//   mul_x      multiplier operand 1 (registered)
//   mul_h      multiplier operand 2 (registered, latched H)
//   mul_res    multiplier product, valid MUL_LAT edges after operand load
//   tag        authentication tag, held until the next tag
//   tag_valid  one-cycle pulse when tag updates
//   busy       message in progress (first block accepted, tag not yet emitted)
//
// Parameter
//   MUL_LAT    multiplier latency in clock edges, legal range 1..15

module ghash_sched #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic [0:127] h_key,
  input  logic [0:127] ek0,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         in_aad,
  input  logic         in_last,
  output logic [0:127] mul_x,
  output logic [0:127] mul_h,
  input  logic [0:127] mul_res,
  output logic [0:127] tag,
  output logic         tag_valid,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BLK = 2'd1,
    ST_WAIT_LEN = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  state_t       r_state;
  logic [0:127] r_y;
  logic [0:127] r_h;
  logic [0:127] r_ek0;
  logic [31:0]  r_aad_cnt;
  logic [31:0]  r_ct_cnt;
  logic [3:0]   r_lat_cnt;
  logic         r_first;   // next accepted block starts a new message
  logic         r_last;    // the block in flight is the final one

  logic [0:127] w_y_cur;
  logic [0:127] w_len_blk;

  // NOTE: in_ready is combinational on i_reset so that no block can be
  // accepted on an edge where reset is also sampled.
  assign in_ready = (r_state == ST_IDLE) && !i_reset;
  assign busy     = !r_first;

  // The first block of a message always chains from Y = 0.
  assign w_y_cur  = r_first ? '0 : r_y;

  // Bit lengths are block counts * 128, zero-extended to 64 bits each;
  // len(A) occupies bits 0..63, len(C) bits 64..127.
  assign w_len_blk = {25'd0, r_aad_cnt, 7'd0, 25'd0, r_ct_cnt, 7'd0};

  // NOTE: every register here is updated with non-blocking assignments so
  // all right-hand sides see the pre-edge state, as the hardware does.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_y       <= '0;
      r_h       <= '0;
      r_ek0     <= '0;
      r_aad_cnt <= '0;
      r_ct_cnt  <= '0;
      r_lat_cnt <= '0;
      r_first   <= 1'b1;
      r_last    <= 1'b0;
      mul_x     <= '0;
      mul_h     <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
    end else begin
      tag_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (r_first) begin
              r_h   <= h_key;
              mul_h <= h_key;
            end else begin
              mul_h <= r_h;
            end
            mul_x <= w_y_cur ^ in_data;
            if (in_aad) r_aad_cnt <= r_aad_cnt + 32'd1;
            else        r_ct_cnt  <= r_ct_cnt + 32'd1;
            if (in_last) begin
              r_ek0  <= ek0;
              r_last <= 1'b1;
            end
            r_first   <= 1'b0;
            r_lat_cnt <= LAT;
            r_state   <= ST_WAIT_BLK;
          end
        end

        ST_WAIT_BLK: begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
          // The counter reaches zero on this edge: the product is ready.
          if (r_lat_cnt == 4'd1) begin
            r_y <= mul_res;
            if (r_last) begin
              mul_x     <= mul_res ^ w_len_blk;
              r_lat_cnt <= LAT;
              r_state   <= ST_WAIT_LEN;
            end else begin
              r_state   <= ST_IDLE;
            end
          end
        end

        ST_WAIT_LEN: begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
          if (r_lat_cnt == 4'd1) begin
            tag       <= mul_res ^ r_ek0;
            tag_valid <= 1'b1;
            r_y       <= '0;
            r_aad_cnt <= '0;
            r_ct_cnt  <= '0;
            r_first   <= 1'b1;
            r_last    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_sched.sv
// tb_ghash_sched
//   Drives three ghash_sched instances (MUL_LAT = 1, 3, 7) through the same
//   directed message sequence, one instance at a time, each paired with a
//   behavioural GF(2^128) multiplier of matching latency. A message-level
//   GHASH model predicts every visible output on every cycle; a few literal
//   tag values pin the model itself.

module tb_ghash_sched;

  localparam int NI = 3;
  localparam logic [0:127] GF_R = 128'hE1000000_00000000_00000000_00000000;
  localparam logic [0:127] H_ID = 128'h80000000_00000000_00000000_00000000;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 7;
    endcase
  endfunction

  // GF(2^128) product in GCM bit order (index 0 = x^0).
  function automatic logic [0:127] gf_mul(input logic [0:127] a, input logic [0:127] b);
    logic [0:127] z;
    logic [0:127] v;
    z = '0;
    v = b;
    for (int i = 0; i < 128; i++) begin
      if (a[i]) z = z ^ v;
      v = v[127] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic clk = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst       [NI];
  logic [0:127] h_key     [NI];
  logic [0:127] ek0       [NI];
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [0:127] in_data   [NI];
  logic         in_aad    [NI];
  logic         in_last   [NI];
  logic [0:127] mul_x     [NI];
  logic [0:127] mul_h     [NI];
  logic [0:127] tag       [NI];
  logic         tag_valid [NI];
  logic         busy      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned LAT = lat_of(g);
    logic [0:127] res;
    logic [0:127] pipe [1:15];

    always @(posedge clk) begin
      pipe[1] <= gf_mul(mul_x[g], mul_h[g]);
      for (int j = 2; j <= 15; j++) pipe[j] <= pipe[j-1];
    end

    if (LAT == 1) begin : g_comb
      assign res = gf_mul(mul_x[g], mul_h[g]);
    end else begin : g_pipe
      assign res = pipe[LAT-1];
    end

    ghash_sched #(.MUL_LAT(LAT)) u_dut (
      .clk       (clk),
      .i_reset   (rst[g]),
      .h_key     (h_key[g]),
      .ek0       (ek0[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_aad    (in_aad[g]),
      .in_last   (in_last[g]),
      .mul_x     (mul_x[g]),
      .mul_h     (mul_h[g]),
      .mul_res   (res),
      .tag       (tag[g]),
      .tag_valid (tag_valid[g]),
      .busy      (busy[g])
    );
  end

  // ---------------------------------------------------------------- checking
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int k,
                       input logic [0:127] act, input logic [0:127] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lat=%0d edge=%0d: got %h want %h", name, lat_of(k), cyc, act, exp);
    end
  endtask

  // Literal tag expectations posted by the stimulus process.
  int           lit_req  [NI];
  int           lit_done [NI];
  int           lit_edge [NI];
  logic [0:127] lit_tag  [NI];

  // Message-level model state, written only by the compare process.
  bit           en       [NI];
  int           free_from[NI];   // first edge count at which in_ready may be high
  bit           in_msg   [NI];
  logic [0:127] m_y      [NI];
  logic [0:127] m_h      [NI];
  int unsigned  m_aad    [NI];
  int unsigned  m_ct     [NI];
  bit           len_pend [NI];
  int           len_edge [NI];
  logic [0:127] len_val  [NI];
  bit           tag_pend [NI];
  int           tag_edge [NI];
  logic [0:127] tag_val  [NI];
  logic [0:127] e_tag    [NI];
  logic [0:127] e_mx     [NI];
  logic [0:127] e_mh     [NI];
  bit           e_tv     [NI];
  bit           e_busy   [NI];

  // At each negedge: compare outputs left by edge cyc, then advance the model
  // to edge cyc+1 using the inputs that edge will sample.
  always @(negedge clk) begin : cmp
    int           n;
    logic [0:127] l_blk;
    for (int k = 0; k < NI; k++) begin
      if (en[k]) begin
        check("in_ready",  k, 128'(in_ready[k]), 128'(!rst[k] && cyc >= free_from[k]));
        check("tag_valid", k, 128'(tag_valid[k]), 128'(e_tv[k]));
        check("tag",       k, tag[k],   e_tag[k]);
        check("busy",      k, 128'(busy[k]), 128'(e_busy[k]));
        check("mul_x",     k, mul_x[k], e_mx[k]);
        check("mul_h",     k, mul_h[k], e_mh[k]);
        if (lit_req[k] != lit_done[k] && cyc == lit_edge[k]) begin
          check("lit_tag",   k, tag[k], lit_tag[k]);
          check("lit_pulse", k, 128'(tag_valid[k]), 128'(1'b1));
          lit_done[k] = lit_req[k];
        end
      end

      n = cyc + 1;
      if (rst[k]) begin
        en[k] = 1'b1;     free_from[k] = 0; in_msg[k] = 1'b0;
        len_pend[k] = 1'b0; tag_pend[k] = 1'b0;
        m_y[k] = '0;      m_aad[k] = 0;     m_ct[k] = 0;
        e_tag[k] = '0;    e_mx[k] = '0;     e_mh[k] = '0;
        e_tv[k] = 1'b0;   e_busy[k] = 1'b0;
      end else if (en[k]) begin
        e_tv[k] = 1'b0;
        if (len_pend[k] && n == len_edge[k]) begin
          e_mx[k] = len_val[k];
          len_pend[k] = 1'b0;
        end
        if (tag_pend[k] && n == tag_edge[k]) begin
          e_tag[k] = tag_val[k];
          e_tv[k] = 1'b1;
          tag_pend[k] = 1'b0;
          in_msg[k] = 1'b0;
        end
        if (in_valid[k] && cyc >= free_from[k]) begin
          if (!in_msg[k]) begin
            in_msg[k] = 1'b1;
            m_y[k] = '0; m_aad[k] = 0; m_ct[k] = 0;
            m_h[k] = h_key[k];
            e_mh[k] = h_key[k];
          end
          e_mx[k] = m_y[k] ^ in_data[k];
          m_y[k] = gf_mul(e_mx[k], m_h[k]);
          if (in_aad[k]) m_aad[k] = m_aad[k] + 1;
          else           m_ct[k]  = m_ct[k] + 1;
          if (in_last[k]) begin
            l_blk = {64'(m_aad[k]) * 64'd128, 64'(m_ct[k]) * 64'd128};
            len_val[k]  = m_y[k] ^ l_blk;
            len_edge[k] = n + lat_of(k);
            len_pend[k] = 1'b1;
            tag_val[k]  = gf_mul(len_val[k], m_h[k]) ^ ek0[k];
            tag_edge[k] = n + 2 * lat_of(k);
            tag_pend[k] = 1'b1;
            free_from[k] = n + 2 * lat_of(k);
          end else begin
            free_from[k] = n + lat_of(k);
          end
        end
        e_busy[k] = in_msg[k];
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  // Offers one block; returns the edge count at which it was accepted.
  task automatic send(input int k, input logic [0:127] d, input bit aad,
                      input bit last, input bit hold, output int acc);
    int budget;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_aad[k]   = aad;
    in_last[k]  = last;
    budget = 0;
    @(negedge clk);
    while (!in_ready[k]) begin
      budget++;
      if (budget > 64) begin
        $display("FAIL hs_timeout lat=%0d: in_ready low for %0d cycles, want 1", lat_of(k), budget);
        $fatal(1, "handshake timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) begin
      in_valid[k] = 1'b0;
      in_data[k]  = ~d;      // junk while idle must be ignored
      in_aad[k]   = ~aad;
      in_last[k]  = ~last;
    end
  endtask

  task automatic expect_tag(input int k, input int acc, input logic [0:127] t);
    lit_tag[k]  = t;
    lit_edge[k] = acc + 2 * lat_of(k);
    lit_req[k]  = lit_req[k] + 1;
  endtask

  task automatic rand_msg(input int k, input int nblk, input bit hchange);
    int acc;
    h_key[k] = rnd128();
    for (int i = 0; i < nblk; i++) begin
      ek0[k] = rnd128();
      send(k, rnd128(), $urandom_range(0, 1) == 1, i == nblk - 1, 1'b0, acc);
      if (hchange) h_key[k] = rnd128();
    end
  endtask

  task automatic run_tests(input int k);
    int acc;
    // H = 0: the hash collapses to zero, tag is ek0.
    h_key[k] = '0;
    ek0[k]   = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
    send(k, 128'h01234567_89ABCDEF_01234567_89ABCDEF, 1'b0, 1'b1, 1'b0, acc);
    expect_tag(k, acc, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA);

    // H = identity, one ciphertext block: tag = X xor {0, 128}.
    h_key[k] = H_ID;
    ek0[k]   = '0;
    send(k, 128'hDEADBEEF_00112233_44556677_8899AABB, 1'b0, 1'b1, 1'b0, acc);
    expect_tag(k, acc, 128'hDEADBEEF_00112233_44556677_8899AA3B);

    // H = identity, 2 AAD + 3 ciphertext blocks back to back, valid held high.
    send(k, 128'h01, 1'b1, 1'b0, 1'b1, acc);
    send(k, 128'h02, 1'b1, 1'b0, 1'b1, acc);
    send(k, 128'h04, 1'b0, 1'b0, 1'b1, acc);
    send(k, 128'h08, 1'b0, 1'b0, 1'b1, acc);
    send(k, 128'h10, 1'b0, 1'b1, 1'b0, acc);
    expect_tag(k, acc, 128'h00000000_00000100_00000000_0000019F);

    // Random keys and data, h_key and ek0 disturbed between blocks.
    rand_msg(k, 1, 1'b0);
    rand_msg(k, 3, 1'b1);
    rand_msg(k, 4, 1'b1);

    // Reset while the length block is in the multiplier.
    h_key[k] = rnd128();
    ek0[k]   = rnd128();
    send(k, rnd128(), 1'b0, 1'b1, 1'b0, acc);
    repeat (lat_of(k)) @(posedge clk);
    #1;
    rst[k] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[k] = 1'b0;

    // One-block AAD message afterwards.
    h_key[k] = H_ID;
    ek0[k]   = 128'h11111111_11111111_11111111_11111111;
    send(k, 128'h01, 1'b1, 1'b1, 1'b0, acc);
    expect_tag(k, acc, 128'h11111111_11111191_11111111_11111110);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k]      = 1'b1;
      in_valid[k] = 1'b1;      // offered during reset, must not be taken
      in_data[k]  = 128'h5A;
      in_aad[k]   = 1'b0;
      in_last[k]  = 1'b1;
      h_key[k]    = H_ID;
      ek0[k]      = '0;
      lit_req[k]  = 0;
      lit_edge[k] = 0;
      lit_tag[k]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      rst[k]      = 1'b0;
      in_valid[k] = 1'b0;
    end
    for (int k = 0; k < NI; k++) run_tests(k);
    repeat (40) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
